// File: rtl/parity_serial_tx_4bit.sv
// rtl/parity_serial_tx_4bit.sv - 4-bit parity frame serializer: start, 4 data LSB first, parity, stop
// Optional macro PARITY_TX_ERR_INJ_EN adds err_inject to invert the parity bit of one frame.
module parity_serial_tx_4bit #(
    parameter int   BIT_DIV    = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       parity_mode,
    input  logic       in_valid,
`ifdef PARITY_TX_ERR_INJ_EN
    input  logic       err_inject,
`endif
    output logic       in_ready,
    output logic       tx_out,
    output logic       tx_bit_stb,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW_RAW = $clog2(BIT_DIV + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] DIV_LAST = CW'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   div_cnt;
    logic [1:0]      bit_idx;
    logic [3:0]      data_q;
    logic            par_q;
    logic            inj;
    logic            bit_end;

`ifdef PARITY_TX_ERR_INJ_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    // Last cycle of the current serial bit; the next level is loaded on this edge.
    assign bit_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            tx_out     <= IDLE_LEVEL;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_bit_stb <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_bit_stb <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    tx_out <= IDLE_LEVEL;
                    if (in_valid) begin
                        data_q     <= data_in;
                        par_q      <= ^data_in ^ parity_mode ^ inj;
                        state      <= START;
                        tx_out     <= ~IDLE_LEVEL;
                        tx_bit_stb <= 1'b1;
                        busy       <= 1'b1;
                        in_ready   <= 1'b0;
                        div_cnt    <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        bit_idx    <= 2'd0;
                        tx_out     <= data_q[0];
                        tx_bit_stb <= 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tx_bit_stb <= 1'b1;
                        if (bit_idx == 2'd3) begin
                            state  <= PARITY;
                            tx_out <= par_q;
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                            tx_out  <= data_q[bit_idx + 2'd1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state      <= STOP;
                        tx_out     <= IDLE_LEVEL;
                        tx_bit_stb <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        tx_out   <= IDLE_LEVEL;
                        tx_done  <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out   <= IDLE_LEVEL;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_serial_tx_4bit.sv
// tb/tb_parity_serial_tx_4bit.sv - directed self-checking bench for parity_serial_tx_4bit
module tb_parity_serial_tx_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] data_in     = 4'h0;
    logic       parity_mode = 1'b0;
    logic       in_valid    = 1'b0;
    logic       in_ready, tx_out, tx_bit_stb, busy, tx_done;

    logic [3:0] data4  = 4'h0;
    logic       mode4  = 1'b0;
    logic       valid4 = 1'b0;
    logic       ready4, tx4, stb4, busy4, done4;

`ifdef PARITY_TX_ERR_INJ_EN
    logic       err_inject  = 1'b0;
    logic       err_inject4 = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    parity_serial_tx_4bit #(.BIT_DIV(1), .IDLE_LEVEL(1'b1)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_mode(parity_mode),
        .in_valid(in_valid),
`ifdef PARITY_TX_ERR_INJ_EN
        .err_inject(err_inject),
`endif
        .in_ready(in_ready), .tx_out(tx_out), .tx_bit_stb(tx_bit_stb),
        .busy(busy), .tx_done(tx_done)
    );

    parity_serial_tx_4bit #(.BIT_DIV(4), .IDLE_LEVEL(1'b1)) u4 (
        .clk(clk), .rst(rst), .data_in(data4), .parity_mode(mode4),
        .in_valid(valid4),
`ifdef PARITY_TX_ERR_INJ_EN
        .err_inject(err_inject4),
`endif
        .in_ready(ready4), .tx_out(tx4), .tx_bit_stb(stb4),
        .busy(busy4), .tx_done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks the 7 bit cycles of a BIT_DIV=1 frame already started, then checks the done cycle.
    task automatic walk_frame1(input string tag, input logic [6:0] exp_bits);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s_bit%0d", tag, i), tx_out, exp_bits[i]);
            check($sformatf("%s_stb%0d", tag, i), tx_bit_stb, 1'b1);
            check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            check($sformatf("%s_rdy%0d", tag, i), in_ready, 1'b0);
            check($sformatf("%s_done%0d", tag, i), tx_done, 1'b0);
            tick();
        end
        check({tag, "_done"}, tx_done, 1'b1);
        check({tag, "_ready"}, in_ready, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_line"}, tx_out, 1'b1);
    endtask

    task automatic send1(input string tag, input logic [3:0] d, input logic m, input logic [6:0] exp_bits);
        data_in     = d;
        parity_mode = m;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        data_in     = ~d;
        parity_mode = ~m;
        walk_frame1(tag, exp_bits);
        tick();
        check({tag, "_done_clear"}, tx_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_line", tx_out, 1'b1);
        check("rst_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_stb", tx_bit_stb, 1'b0);
        check("rst_ready4", ready4, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_line", tx_out, 1'b1);
            check("idle_ready", in_ready, 1'b1);
            check("idle_busy", busy, 1'b0);
        end

        // 1011 even -> 0,1,1,0,1,1,1
        send1("even_b", 4'b1011, 1'b0, 7'b1110110);
        // 0000 odd -> 0,0,0,0,0,1,1
        send1("odd_0", 4'b0000, 1'b1, 7'b1100000);
        // 0000 even -> parity 0
        send1("even_0", 4'b0000, 1'b0, 7'b1000000);

        // Back-to-back: A then 5 with in_valid held; mid-frame input changes ignored.
        data_in     = 4'hA;
        parity_mode = 1'b0;
        in_valid    = 1'b1;
        tick();
        data_in     = 4'h5;
        walk_frame1("b2b_a", 7'b1010100);
        tick();
        in_valid    = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                data_in     = 4'hF;
                parity_mode = 1'b1;
            end
            check($sformatf("b2b_5_bit%0d", i), tx_out, logic'((7'b1001010 >> i) & 7'd1));
            check($sformatf("b2b_5_stb%0d", i), tx_bit_stb, 1'b1);
            tick();
        end
        check("b2b_5_done", tx_done, 1'b1);
        tick();

        // Reset during DATA bit 2, with in_valid also high: reset wins.
        data_in     = 4'b1011;
        parity_mode = 1'b0;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_d2", tx_out, 1'b0);
        check("pre_rst_busy", busy, 1'b1);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_line", tx_out, 1'b1);
        check("abort_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", tx_done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_done", tx_done, 1'b0);
            check("abort_no_busy", busy, 1'b0);
        end

        // BIT_DIV=4, 0110 even -> bits 0,0,1,1,0,0,1, each 4 cycles.
        data4  = 4'h6;
        mode4  = 1'b0;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        data4  = 4'h9;
        for (int b = 0; b < 7; b++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("div4_bit%0d_%0d", b, c), tx4, logic'((7'b1001100 >> b) & 7'd1));
                check($sformatf("div4_stb%0d_%0d", b, c), stb4, logic'(c == 0));
                check($sformatf("div4_busy%0d_%0d", b, c), busy4, 1'b1);
                tick();
            end
        end
        check("div4_done", done4, 1'b1);
        check("div4_ready", ready4, 1'b1);
        check("div4_idle", busy4, 1'b0);
        tick();

`ifdef PARITY_TX_ERR_INJ_EN
        // 1011 even with err_inject -> parity bit 0 instead of 1.
        err_inject = 1'b1;
        send1("inj", 4'b1011, 1'b0, 7'b1010110);
        err_inject = 1'b0;
        send1("inj_off", 4'b1011, 1'b0, 7'b1110110);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
